// File: rtl/adma2_blk_seq_if.sv
// rtl/adma2_blk_seq_if.sv - host/ADMA2 signal bundle for the multi-block sequencer
interface adma2_blk_seq_if #(
    parameter int BLK_CNT_W = 16,
    parameter int ADDR_W    = 32
);
    logic                 start_xfer;
    logic [BLK_CNT_W-1:0] blk_count;
    logic [ADDR_W-1:0]    sys_addr_base;
    logic                 abort;
    logic                 adma_sar_inc_strb;
    logic                 dat_tf_done;
    logic                 strt_adma_strb;
    logic                 continue_blk_send;
    logic [ADDR_W-1:0]    adma_sys_addr;
    logic [BLK_CNT_W-1:0] blks_remaining;
    logic                 busy;
    logic                 xfer_cmplt;
    logic                 xfer_tmo;
    logic                 xfer_abrt;

    modport master (
        output start_xfer, blk_count, sys_addr_base, abort, adma_sar_inc_strb, dat_tf_done,
        input  strt_adma_strb, continue_blk_send, adma_sys_addr, blks_remaining, busy,
               xfer_cmplt, xfer_tmo, xfer_abrt
    );

    modport slave (
        input  start_xfer, blk_count, sys_addr_base, abort, adma_sar_inc_strb, dat_tf_done,
        output strt_adma_strb, continue_blk_send, adma_sys_addr, blks_remaining, busy,
               xfer_cmplt, xfer_tmo, xfer_abrt
    );
endinterface

// File: rtl/adma2_blk_seq.sv
// rtl/adma2_blk_seq.sv - multi-block sequencer issuing ADMA2 start/continue strobes
module adma2_blk_seq #(
    parameter int BLK_CNT_W = 16,
    parameter int ADDR_W    = 32,
    parameter int BLK_BYTES = 512,
    parameter int GAP_CYC   = 2,
    parameter int TMO_CYC   = 65535
) (
    input  logic            clk,
    input  logic            reset,
    adma2_blk_seq_if.slave  bus
);
    // Timer only has to reach TMO_CYC-1; gap counter counts down from GAP_CYC-1.
    localparam int TMR_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TMR_W-1:0]     TMR_LAST  = TMR_W'(TMO_CYC - 1);
    localparam logic [TMR_W-1:0]     TMR_ONE   = TMR_W'(1);
    localparam logic [GAP_W-1:0]     GAP_LOAD  = GAP_W'(GAP_CYC - 1);
    localparam logic [GAP_W-1:0]     GAP_ONE   = GAP_W'(1);
    localparam logic [ADDR_W-1:0]    ADDR_STEP = ADDR_W'(BLK_BYTES);
    localparam logic [BLK_CNT_W-1:0] CNT_ONE   = BLK_CNT_W'(1);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t               state;
    logic [TMR_W-1:0]     timer;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 strt_q, cont_q, busy_q, cmplt_q, tmo_q, abrt_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [BLK_CNT_W-1:0] rem_q;
    logic [BLK_CNT_W-1:0] rem_dec;
    logic                 tmo_hit;

    // Remaining count after the current block completes, and timeout condition.
    assign rem_dec = rem_q - CNT_ONE;
    assign tmo_hit = (TMO_CYC != 0) && (timer == TMR_LAST);

    // Sequencer FSM: launches blocks, tracks address/count, reports termination.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            gap_cnt <= '0;
            strt_q  <= 1'b0;
            cont_q  <= 1'b0;
            busy_q  <= 1'b0;
            cmplt_q <= 1'b0;
            tmo_q   <= 1'b0;
            abrt_q  <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            strt_q  <= 1'b0;
            cont_q  <= 1'b0;
            cmplt_q <= 1'b0;
            tmo_q   <= 1'b0;
            abrt_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_xfer) begin
                        if (bus.blk_count != '0) begin
                            rem_q  <= bus.blk_count;
                            addr_q <= bus.sys_addr_base;
                            strt_q <= 1'b1;
                            timer  <= '0;
                            busy_q <= 1'b1;
                            state  <= XFER;
                        end else begin
                            cmplt_q <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (bus.adma_sar_inc_strb) begin
                        addr_q <= addr_q + ADDR_STEP;
                    end
                    if (bus.abort) begin
                        abrt_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (bus.dat_tf_done) begin
                        rem_q <= rem_dec;
                        if (rem_dec == '0) begin
                            cmplt_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end
                    end else if (tmo_hit) begin
                        tmo_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        abrt_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (gap_cnt == '0) begin
                        cont_q <= 1'b1;
                        timer  <= '0;
                        state  <= XFER;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.strt_adma_strb    = strt_q;
    assign bus.continue_blk_send = cont_q;
    assign bus.adma_sys_addr     = addr_q;
    assign bus.blks_remaining    = rem_q;
    assign bus.busy              = busy_q;
    assign bus.xfer_cmplt        = cmplt_q;
    assign bus.xfer_tmo          = tmo_q;
    assign bus.xfer_abrt         = abrt_q;
endmodule
